mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, fixed-latency instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined core. It arbitrates between the two stages and runs a multi-cycle access sequence against the RAM. It returns read data and a one-cycle ready pulse to the winning stage. The core's hazard unit stalls a stage while that stage's request is outstanding and its ready has not yet pulsed.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 4, RAM access latency in cycles; legal range ≥1.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- if_req  in  1  IF fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req high.
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready=1, held until next IF completion.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_rd_req  in  1  load request.
- mem_wr_req  in  1  store request.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid when mem_ready=1 on a read; unchanged by writes.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- busy  out  1  high in ACCESS and DONE.
- ram_en  out  1  RAM enable; high throughout ACCESS.
- ram_we  out  1  RAM write enable; high throughout ACCESS for writes only.
- ram_addr  out  ADDR_W  latched access address.
- ram_wdata  out  DATA_W  latched write data.
- ram_rdata  in  DATA_W  RAM read data; valid on the last ACCESS cycle.

## Operation
- **Reset values.** While reset is low, all outputs are 0: if_rdata, mem_rdata, if_ready, mem_ready, busy, ram_en, ram_we, ram_addr, ram_wdata. State is IDLE and the counter is 0.
- **States.**
  - IDLE → ACCESS when any request is high.
  - ACCESS → DONE when cnt == WAIT_CYCLES-1; otherwise cnt increments.
  - DONE → IDLE unconditionally.
- **Arbitration in IDLE.** Fixed priority: MEM over IF, because MEM holds the older instruction.
  - If mem_wr_req=1: owner=MEM and the access is a write (mem_wr_req wins over mem_rd_req if both are high).
  - Else if mem_rd_req=1: owner=MEM, read.
  - Else if if_req=1: owner=IF, read.
- **Latching on the IDLE→ACCESS edge.** Owner, write flag, address and wdata are captured and cnt is reset to 0. ram_addr, ram_wdata and ram_we are driven from these registers only, so they are stable through ACCESS and DONE.
- **Read data capture.** For a read, ram_rdata is sampled on the ACCESS→DONE edge into the owner's rdata register. The other stage's rdata register is untouched.
- **Ready.** In DONE, the owner's ready is 1 for exactly one cycle; the other stage's ready stays 0.
- **Mid-access request changes.** Requests that change during ACCESS or DONE are ignored. A withdrawn request still completes and still pulses ready. Requests still high in the cycle after DONE are treated as new requests.
- **Reset mid-operation.** The access is aborted immediately: ram_en and ram_we drop asynchronously and no ready pulse is issued. After release, pending requests are arbitrated fresh from IDLE.

## Timing
- Take cycle 0 as the cycle in which a request is high in IDLE.
  - ACCESS occupies cycles 1..WAIT_CYCLES; ram_en is high in exactly these cycles.
  - DONE is cycle WAIT_CYCLES+1; ready is high and data is valid in this cycle.
- Latency is WAIT_CYCLES+1 cycles from request to ready.
- Back-to-back accesses: the next access starts in cycle WAIT_CYCLES+2 (IDLE) and enters ACCESS in cycle WAIT_CYCLES+3. Peak throughput is one access per WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=1: ACCESS is 1 cycle and ready arrives in cycle 2.
- Outputs are registered; there is no combinational path from any request to ready, ram_* or busy.

## Test plan
- **Reset.** Hold reset=0 with all requests high for 20 cycles → every output is 0 and ram_en never rises. Release → ACCESS begins on the next edge with owner=MEM.
- **Single IF read.** WAIT_CYCLES=4, if_req with if_addr=0x10, RAM returns 0xDEADBEEF → ram_en=1 and ram_addr=0x10 in cycles 1–4; if_ready=1 only in cycle 5 with if_rdata=0xDEADBEEF; mem_ready stays 0.
- **Simultaneous requests.** if_req and mem_rd_req (addr 0x40 → 0xCAFEF00D) rise in cycle 0, both held → mem_ready in cycle 5 with mem_rdata=0xCAFEF00D; IF access is cycles 7–10; if_ready in cycle 11.
- **Store.** mem_wr_req with addr 0x20, wdata 0x12345678 → ram_we=1 and ram_wdata=0x12345678 in cycles 1–4; mem_ready in cycle 5; mem_rdata keeps its previous value. Repeat with mem_rd_req also high → still a write.
- **Reset mid-access.** Pull reset low in cycle 2 of an IF read → ram_en and busy drop within that cycle and no if_ready pulse occurs. Release with if_req still high → a full fresh access runs and ready arrives WAIT_CYCLES+1 cycles after release.
- **Withdrawn request.** Drop if_req in cycle 2 → access completes and if_ready still pulses in cycle 5. Run the same test with WAIT_CYCLES=1 → if_ready in cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port RAM between the IF and MEM stages.
// Fixed priority (MEM over IF); each access runs IDLE -> ACCESS -> DONE.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_rd_req,
   input  logic              mem_wr_req,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              busy,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               own_mem_q, own_mem_d;
   logic               wr_q, wr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      own_mem_d   = own_mem_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         IDLE: begin
            if (mem_wr_req || mem_rd_req || if_req) begin
               state_d = ACCESS;
               cnt_d   = '0;
               wdata_d = mem_wdata;
               // MEM holds the older instruction, so it always wins; a store beats a load
               if (mem_wr_req || mem_rd_req) begin
                  own_mem_d = 1'b1;
                  wr_d      = mem_wr_req;
                  addr_d    = mem_addr;
               end else begin
                  own_mem_d = 1'b0;
                  wr_d      = 1'b0;
                  addr_d    = if_addr;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               if (!wr_q) begin
                  if (own_mem_q) mem_rdata_d = ram_rdata;
                  else           if_rdata_d  = ram_rdata;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         own_mem_q   <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         own_mem_q   <= own_mem_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Pure decodes of registered state: no request-to-output combinational path
   assign busy      = (state_q != IDLE);
   assign ram_en    = (state_q == ACCESS);
   assign ram_we    = (state_q == ACCESS) && wr_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign if_ready  = (state_q == DONE) && !own_mem_q;
   assign mem_ready = (state_q == DONE) &&  own_mem_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one WAIT_CYCLES=4 instance and one
// WAIT_CYCLES=1 instance sharing stimulus; each checks against hand-computed values.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0, mem_rd_req = 1'b0, mem_wr_req = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;

   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
   logic        if_ready, mem_ready, busy, ram_en, ram_we;
   logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
   logic        if_ready1, mem_ready1, busy1, ram_en1, ram_we1;

   int n_cmp = 0;
   int n_err = 0;
   logic saw_en;

   always #5 clk = ~clk;

   // RAM contents: two fixed words, everything else derived from the address
   function automatic logic [31:0] ram_word(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      if (a == 32'h40) return 32'hCAFEF00D;
      return a ^ 32'hA5A5_0000;
   endfunction

   assign ram_rdata  = ram_word(ram_addr);
   assign ram_rdata1 = ram_word(ram_addr1);

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ready(if_ready1),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
      .busy(busy1), .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
      .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // ---- Reset held with all requests high ----
      if_req = 1; mem_rd_req = 1; mem_wr_req = 1;
      if_addr = 32'h10; mem_addr = 32'h20; mem_wdata = 32'h1111_2222;
      saw_en = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ram_en) saw_en = 1'b1;
         chk($sformatf("rst_outs_%0d", i),
             {if_rdata, mem_rdata, if_ready, mem_ready, busy, ram_en, ram_we, ram_addr, ram_wdata}, '0);
      end
      chk("rst_no_en", saw_en, 1'b0);
      reset = 1'b1;                       // cycle 0: IDLE with requests
      step();                             // cycle 1
      chk("rel_busy", busy, 1'b1);
      chk("rel_en",   ram_en, 1'b1);
      chk("rel_we_mem_write", ram_we, 1'b1);
      chk("rel_addr", ram_addr, 32'h20);
      if_req = 0; mem_rd_req = 0; mem_wr_req = 0;
      idle(4);                            // cycle 5
      chk("rel_mem_ready", {mem_ready, if_ready}, 2'b10);
      chk("rel_mem_rdata_kept", mem_rdata, 32'h0);
      idle(4);

      // ---- Single IF read ----
      if_req = 1; if_addr = 32'h10;
      chk("if_c0_busy", busy, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("if_c%0d_en_addr", c), {ram_en, ram_we, ram_addr, if_ready}, {1'b1, 1'b0, 32'h10, 1'b0});
      end
      step();                             // cycle 5
      chk("if_c5_ready", {if_ready, mem_ready, ram_en}, 3'b100);
      chk("if_c5_rdata", if_rdata, 32'hDEADBEEF);
      if_req = 0;
      step();
      chk("if_c6_idle", {if_ready, busy}, 2'b00);
      idle(3);

      // ---- Simultaneous IF + load ----
      if_req = 1; if_addr = 32'h14;
      mem_rd_req = 1; mem_addr = 32'h40;
      step();
      chk("sim_c1_addr", ram_addr, 32'h40);
      idle(4);                            // cycle 5
      chk("sim_c5_ready", {mem_ready, if_ready}, 2'b10);
      chk("sim_c5_rdata", mem_rdata, 32'hCAFEF00D);
      mem_rd_req = 0;
      step();                             // cycle 6
      chk("sim_c6_idle", busy, 1'b0);
      step();                             // cycle 7
      chk("sim_c7_if_access", {ram_en, ram_addr}, {1'b1, 32'h14});
      idle(3);                            // cycle 10
      chk("sim_c10_no_ready", if_ready, 1'b0);
      step();                             // cycle 11
      chk("sim_c11_if_ready", {if_ready, mem_ready}, 2'b10);
      chk("sim_c11_if_rdata", if_rdata, 32'hA5A5_0014);
      chk("sim_mem_rdata_kept", mem_rdata, 32'hCAFEF00D);
      if_req = 0;
      idle(4);

      // ---- Store, then store with load also requested ----
      mem_wr_req = 1; mem_addr = 32'h20; mem_wdata = 32'h12345678;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("st_c%0d_we", c), {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 32'h20, 32'h12345678});
      end
      step();
      chk("st_c5_ready", {mem_ready, if_ready, ram_we}, 3'b100);
      chk("st_mem_rdata_kept", mem_rdata, 32'hCAFEF00D);
      mem_wr_req = 0;
      idle(4);
      mem_wr_req = 1; mem_rd_req = 1; mem_addr = 32'h24; mem_wdata = 32'h9ABCDEF0;
      step();
      chk("st2_c1_we", {ram_we, ram_wdata}, {1'b1, 32'h9ABCDEF0});
      idle(4);
      chk("st2_c5_ready", mem_ready, 1'b1);
      chk("st2_mem_rdata_kept", mem_rdata, 32'hCAFEF00D);
      mem_wr_req = 0; mem_rd_req = 0;
      idle(4);

      // ---- Reset in the middle of an IF read ----
      if_req = 1; if_addr = 32'h30;
      idle(2);                            // cycle 2
      chk("rm_c2_en_before", ram_en, 1'b1);
      reset = 1'b0;
      #1;
      chk("rm_drop", {ram_en, busy, if_ready}, 3'b000);
      saw_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (if_ready || ram_en) saw_en = 1'b1;
      end
      chk("rm_no_pulse", saw_en, 1'b0);
      reset = 1'b1;                       // fresh cycle 0
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("rm_c%0d", c), {ram_en, if_ready}, 2'b10);
      end
      step();
      chk("rm_c5_ready", if_ready, 1'b1);
      chk("rm_c5_rdata", if_rdata, 32'hA5A5_0030);
      if_req = 0;
      idle(4);

      // ---- Withdrawn request, both latencies ----
      if_req = 1; if_addr = 32'h50;
      step();                             // cycle 1
      chk("wd_c1_w1_not_ready", if_ready1, 1'b0);
      step();                             // cycle 2
      if_req = 0;
      chk("wd_c2_w1_ready", if_ready1, 1'b1);
      chk("wd_c2_w1_rdata", if_rdata1, 32'hA5A5_0050);
      chk("wd_c2_w4_busy", {busy, if_ready}, 2'b10);
      idle(2);                            // cycle 4
      chk("wd_c4_w4_not_ready", if_ready, 1'b0);
      step();                             // cycle 5
      chk("wd_c5_w4_ready", if_ready, 1'b1);
      chk("wd_c5_w4_rdata", if_rdata, 32'hA5A5_0050);
      step();
      chk("wd_c6_idle", {busy, busy1}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
